mul16_share_arb: RTL
====================

// Module: mul16_share_arb
// PURPOSE
//  Shares one combinational multiplier16b (16x16 -> 32, unsigned) among NREQ requesters.
//  Round-robin arbitration, registered operands, registered result with tag.
//  Two-stage pipeline with valid/ready on both sides; one product per cycle sustained.
//  Sits between the multiplier datapath and the client blocks that need products.
// PARAMETERS
//  NREQ  4               number of requesters, 1..16
//  IDW   $clog2(NREQ)>1  width of the requester tag (minimum 1)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   NREQ      request i presents operands
//  req_ready  out  NREQ      one-hot grant; request i accepted when valid&ready
//  req_x      in   NREQ*16   multiplicand of requester i, bits [16i+15:16i]
//  req_y      in   NREQ*16   multiplier of requester i
//  rsp_valid  out  1         product available
//  rsp_ready  in   1         consumer takes product
//  rsp_id     out  IDW       index of the requester owning rsp_z
//  rsp_z      out  32        req_x*req_y, unsigned, full width (no truncation)
//  busy       out  1         s1_v | s2_v
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   s1_v=0, s2_v=0, rr_ptr=0, rsp_z=0, rsp_id=0, all outputs low.
//  Pipeline:
//   S1 = operand register (x,y,id,s1_v); S2 = result register (z,id,s2_v).
//   adv2 = !s2_v | rsp_ready; adv1 = !s1_v | adv2.
//   At an edge with adv2: S2 <= {multiplier16b(S1.x,S1.y), S1.id, s1_v}.
//   At an edge with adv1: S1 <= {granted operands, grant id, any accept}.
//   Latency: accepted at edge k -> rsp_valid high after edge k+1.
//  Arbitration:
//   Grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   req_ready = onehot(grant) & {NREQ{adv1}}; all zero when no req_valid.
//   On accept: rr_ptr <= grant+1 mod NREQ; otherwise rr_ptr holds.
//   req_ready depends combinationally on req_valid and rsp_ready, never on x/y.
//  Handshake rules:
//   rsp_valid, rsp_id, rsp_z stable while rsp_valid & !rsp_ready.
//   A requester that is not granted must hold its operands; no request is dropped or duplicated.
//   Full: s1_v & s2_v & !rsp_ready -> req_ready all 0.
//   Empty plus one request -> accepted in the same cycle.
//   Accept and retire in the same cycle give no bubble.
//  Boundaries:
//   NREQ=1: rr_ptr constant 0, rsp_id=0.
//   rr_ptr wraps NREQ-1 -> 0.
//   0*y=0; FFFF*FFFF=FFFE0001.
//   Reset mid-operation discards in-flight results: rsp_valid=0 immediately, rr_ptr=0.
// STRUCTURE
//  Package mul_pkg: OPW=16, ZW=32, typedef op_t [15:0], prod_t [31:0], function id_w(n).
//  Sub-module rr_arbiter #(N): inputs req, ptr; outputs onehot grant, grant_idx, any.
//  Multiplier: one instance of the existing multiplier16b, fed from S1.
//  The pipeline control and rr_ptr register stay in this module.
// TESTING
//  1 Only req0: x=3, y=5 -> req_ready[0]=1 that cycle; rsp_valid 2 edges later, z=15, id=0.
//  2 req2: x=FFFF, y=FFFF, then x=0, y=1234 -> z=FFFE0001 then 0, both id=2, in order.
//  3 All 4 valid continuously, rsp_ready=1, 8 cycles -> ids 0,1,2,3,0,1,2,3, one per cycle.
//  4 rsp_ready=0 for 5 cycles, all requests valid -> 2 accepts then req_ready=0;
//    rsp outputs frozen; after release the order resumes with no loss.
//  5 rst_n pulsed low while s1_v=s2_v=1 -> rsp_valid=0, busy=0 asynchronously;
//    after release req3 alone -> id=3, grant order from rr_ptr=0.
//  6 10k random x, y, valid, rsp_ready vs a scoreboard (x*y per id, FIFO order)
//    -> zero mismatches, per-requester starvation <= NREQ grants.

Source files
------------

// File: rtl/mul16_share_arb_pkg.sv
// Shared widths, operand/product types and the tag-width helper for the multiplier arbiter.
package mul16_share_arb_pkg;

    localparam int unsigned OPW = 16;
    localparam int unsigned ZW  = 32;

    typedef logic [OPW-1:0] op_t;
    typedef logic [ZW-1:0]  prod_t;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul16_share_arb_if.sv
// Request/response bus between client blocks (master) and the shared multiplier (slave).
interface mul16_share_arb_if
    import mul16_share_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = id_w(NREQ)
) ();

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_x;
    logic [NREQ*OPW-1:0] req_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    prod_t               rsp_z;
    logic                busy;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, busy
    );

endinterface

// File: rtl/mul16_share_arb_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr_i, wrapping modulo N.
module mul16_share_arb_rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_c_o,
    output logic [IDW-1:0] grant_idx_c_o,
    output logic           any_c_o
);

    int unsigned dist_c;
    int unsigned best_d_c;
    int unsigned best_i_c;

    // Pick the requester with the smallest rotational distance from the pointer.
    always_comb begin
        grant_c_o     = '0;
        grant_idx_c_o = '0;
        any_c_o       = 1'b0;
        dist_c        = 0;
        best_d_c      = N;
        best_i_c      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i >= 32'(ptr_i)) begin
                dist_c = i - 32'(ptr_i);
            end else begin
                dist_c = i + N - 32'(ptr_i);
            end
            if (req_i[i] && (dist_c < best_d_c)) begin
                best_d_c = dist_c;
                best_i_c = i;
            end
        end
        any_c_o = (best_d_c < N);
        for (int unsigned i = 0; i < N; i++) begin
            grant_c_o[i] = any_c_o && (best_i_c == i);
        end
        grant_idx_c_o = IDW'(best_i_c);
    end

endmodule

// File: rtl/multiplier16b.sv
// Existing combinational 16x16 -> 32 unsigned multiplier.
module multiplier16b
    import mul16_share_arb_pkg::*;
(
    input  op_t   x_i,
    input  op_t   y_i,
    output prod_t z_c_o
);

    // Full-width unsigned product, no truncation.
    assign z_c_o = ZW'(x_i) * ZW'(y_i);

endmodule

// File: rtl/mul16_share_arb.sv
// One multiplier shared by NREQ clients: round-robin grant, operand stage S1, result stage S2.
module mul16_share_arb
    import mul16_share_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    mul16_share_arb_if.slave  bus
);

    logic            s1_v_q;
    op_t             s1_x_q;
    op_t             s1_y_q;
    logic [IDW-1:0]  s1_id_q;
    logic            s2_v_q;
    prod_t           s2_z_q;
    logic [IDW-1:0]  s2_id_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;

    logic            adv1_c;
    logic            adv2_c;
    logic            accept_c;
    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  grant_idx_c;
    logic            any_c;
    op_t             sel_x_c;
    op_t             sel_y_c;
    prod_t           prod_c;

    // Stage advance: S2 frees when empty or drained, S1 frees when empty or S2 moves.
    assign adv2_c   = !s2_v_q || bus.rsp_ready;
    assign adv1_c   = !s1_v_q || adv2_c;
    assign accept_c = any_c && adv1_c;

    mul16_share_arb_rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req_i         (bus.req_valid),
        .ptr_i         (rr_ptr_q),
        .grant_c_o     (grant_c),
        .grant_idx_c_o (grant_idx_c),
        .any_c_o       (any_c)
    );

    // Grant depends only on valids and downstream space, never on operand values.
    assign bus.req_ready = grant_c & {NREQ{adv1_c}};

    // Route the granted requester's operands into S1.
    always_comb begin
        sel_x_c = '0;
        sel_y_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                sel_x_c = bus.req_x[i*OPW +: OPW];
                sel_y_c = bus.req_y[i*OPW +: OPW];
            end
        end
    end

    // Pointer moves past the winner on accept, wrapping at NREQ-1.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept_c) begin
            if (grant_idx_c == IDW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_c + IDW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // S1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_x_q  <= '0;
            s1_y_q  <= '0;
            s1_id_q <= '0;
        end else if (adv1_c) begin
            s1_v_q  <= any_c;
            s1_x_q  <= sel_x_c;
            s1_y_q  <= sel_y_c;
            s1_id_q <= grant_idx_c;
        end
    end

    multiplier16b u_mul (
        .x_i   (s1_x_q),
        .y_i   (s1_y_q),
        .z_c_o (prod_c)
    );

    // S2 result register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q  <= 1'b0;
            s2_z_q  <= '0;
            s2_id_q <= '0;
        end else if (adv2_c) begin
            s2_v_q  <= s1_v_q;
            s2_z_q  <= prod_c;
            s2_id_q <= s1_id_q;
        end
    end

    assign bus.rsp_valid = s2_v_q;
    assign bus.rsp_z     = s2_z_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.busy      = s1_v_q | s2_v_q;

endmodule
